// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle processor control path.
package proc_ctrl_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned STATE_W  = 3;

  localparam logic [OPC_W-1:0] OP_JUMP   = 4'b0000;
  localparam logic [OPC_W-1:0] OP_RTYPE  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_LW     = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SW     = 4'b0011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 4'b0100;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_JMP   = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_JUMP,
    CLS_BRANCH,
    CLS_LW,
    CLS_SW,
    CLS_RTYPE
  } op_class_e;

  // Datapath control strobes issued in one cycle
  typedef struct packed {
    logic                mem_req;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                pc_write;
    logic                branch;
    logic                jump;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                instr_done;
    logic                fault;
  } ctrl_t;

  // Map a raw opcode onto its execution class; unknown opcodes run as R-type
  function automatic op_class_e classify(input logic [OPC_W-1:0] op);
    op_class_e cls;
    cls = CLS_RTYPE;
    case (op)
      OP_JUMP:   cls = CLS_JUMP;
      OP_RTYPE:  cls = CLS_RTYPE;
      OP_LW:     cls = CLS_LW;
      OP_SW:     cls = CLS_SW;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_RTYPE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the sequencer and the datapath/memory side.
interface multicycle_control_fsm_if #(
  parameter int unsigned OPCODE_W = 4
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                pc_write;
  logic                branch;
  logic                jump;
  logic [1:0]          alu_op;
  logic                alu_src;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                instr_done;
  logic                fault;
  logic [2:0]          state;

  modport master (
    input  run, opcode, mem_ready,
    output mem_req, mem_read, mem_write, ir_write, pc_write, branch, jump,
           alu_op, alu_src, reg_dst, mem_to_reg, reg_write, instr_done,
           fault, state
  );

  modport slave (
    output run, opcode, mem_ready,
    input  mem_req, mem_read, mem_write, ir_write, pc_write, branch, jump,
           alu_op, alu_src, reg_dst, mem_to_reg, reg_write, instr_done,
           fault, state
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags when the limit is reached.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4   // 2**TMO_W must exceed MEM_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic wait_en,
  output logic expired_c
);

  logic [TMO_W-1:0] count;

  // Wait counter; saturates at the limit so it never wraps back to zero
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wait_en && !expired_c) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expired_c = (count == TMO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC, MEM, WB with memory timeout.
module multicycle_control_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = OPC_W,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4
) (
  input logic                       clock,
  input logic                       reset,
  multicycle_control_fsm_if.master  bus
);

  state_e              state_q;
  state_e              state_d;
  state_e              done_next_c;
  logic [OPCODE_W-1:0] op_q;
  op_class_e           cls_c;
  ctrl_t               ctrl_c;
  logic                tmo_clear_c;
  logic                tmo_wait_c;
  logic                tmo_expired_c;

  assign cls_c       = classify(OPC_W'(op_q));
  assign done_next_c = bus.run ? ST_FETCH : ST_IDLE;

  // State register and opcode latch (captured during DECODE)
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        op_q <= bus.opcode;
      end
    end
  end

  // Timer restarts whenever a memory-waiting state is freshly entered
  assign tmo_wait_c  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;
  assign tmo_clear_c = (state_d != state_q) &&
                       ((state_d == ST_FETCH) || (state_d == ST_MEM));

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_mem_wait_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (tmo_clear_c),
    .wait_en   (tmo_wait_c),
    .expired_c (tmo_expired_c)
  );

  // Next-state and control decode; mem_ready in the expiry cycle still wins
  always_comb begin
    state_d       = state_q;
    ctrl_c        = '0;
    ctrl_c.alu_op = ALU_ADD;

    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        ctrl_c.mem_req  = 1'b1;
        ctrl_c.mem_read = 1'b1;
        if (bus.mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = ST_DECODE;
        end else if (tmo_expired_c) begin
          state_d = ST_FAULT;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        case (cls_c)
          CLS_JUMP: begin
            ctrl_c.jump       = 1'b1;
            ctrl_c.pc_write   = 1'b1;
            ctrl_c.alu_op     = ALU_JMP;
            ctrl_c.instr_done = 1'b1;
            state_d           = done_next_c;
          end
          CLS_BRANCH: begin
            ctrl_c.branch     = 1'b1;
            ctrl_c.alu_op     = ALU_SUB;
            ctrl_c.instr_done = 1'b1;
            state_d           = done_next_c;
          end
          CLS_LW, CLS_SW: begin
            ctrl_c.alu_op  = ALU_ADD;
            ctrl_c.alu_src = 1'b1;
            state_d        = ST_MEM;
          end
          default: begin
            ctrl_c.alu_op = ALU_FUNCT;
            state_d       = ST_WB;
          end
        endcase
      end

      ST_MEM: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.mem_read  = (cls_c == CLS_LW);
        ctrl_c.mem_write = (cls_c != CLS_LW);
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.alu_src   = 1'b1;
        if (bus.mem_ready) begin
          if (cls_c == CLS_LW) begin
            state_d = ST_WB;
          end else begin
            ctrl_c.instr_done = 1'b1;
            state_d           = done_next_c;
          end
        end else if (tmo_expired_c) begin
          state_d = ST_FAULT;
        end
      end

      ST_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.instr_done = 1'b1;
        if (cls_c == CLS_LW) begin
          ctrl_c.mem_to_reg = 1'b1;
        end else begin
          ctrl_c.reg_dst = 1'b1;
        end
        state_d = done_next_c;
      end

      ST_FAULT: begin
        ctrl_c.fault = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (reset) begin
      ctrl_c = '0;
    end
  end

  // Drive the bundle; debug state reads as IDLE while reset is held
  assign bus.mem_req    = ctrl_c.mem_req;
  assign bus.mem_read   = ctrl_c.mem_read;
  assign bus.mem_write  = ctrl_c.mem_write;
  assign bus.ir_write   = ctrl_c.ir_write;
  assign bus.pc_write   = ctrl_c.pc_write;
  assign bus.branch     = ctrl_c.branch;
  assign bus.jump       = ctrl_c.jump;
  assign bus.alu_op     = ctrl_c.alu_op;
  assign bus.alu_src    = ctrl_c.alu_src;
  assign bus.reg_dst    = ctrl_c.reg_dst;
  assign bus.mem_to_reg = ctrl_c.mem_to_reg;
  assign bus.reg_write  = ctrl_c.reg_write;
  assign bus.instr_done = ctrl_c.instr_done;
  assign bus.fault      = ctrl_c.fault;
  assign bus.state      = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: step-sequence model plus directed literals.
module tb_multicycle_control_fsm;

  localparam int K_IDLE = 0, K_F = 1, K_D = 2, K_E = 3, K_M = 4, K_W = 5, K_FAULT = 7;
  localparam int C_JMP = 0, C_BR = 1, C_LW = 2, C_SW = 3, C_R = 4;
  localparam int TMO = 15;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Instruction class from opcode; anything unlisted behaves as R-type
  function automatic int cls_of(input logic [3:0] op);
    case (op)
      4'b0000: return C_JMP;
      4'b0010: return C_LW;
      4'b0011: return C_SW;
      4'b0100: return C_BR;
      default: return C_R;
    endcase
  endfunction

  // Number of steps an instruction of this class takes
  function automatic int seq_len(input int c);
    if (c == C_JMP || c == C_BR) return 3;
    if (c == C_LW) return 5;
    return 4;
  endfunction

  // Which kind of step the instruction performs at position i
  function automatic int kind_at(input int c, input int i);
    if (i == 0) return K_F;
    if (i == 1) return K_D;
    if (i == 2) return K_E;
    if (i == 3) return (c == C_LW || c == C_SW) ? K_M : K_W;
    return K_W;
  endfunction

  task automatic chk1(input string name, input logic got, input int exp);
    checks++;
    if (got !== 1'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] got, input int exp);
    checks++;
    if (got !== 2'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] got, input int exp);
    checks++;
    if (got !== 3'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Behavioural model: instruction as a sequence of steps, checked every cycle
  initial begin : model
    int mode, i, wt, cls;
    int n_mode, n_i, n_wt, n_cls;
    int kind, e_state;
    bit memstep, completes, last;
    bit e_req, e_rd, e_wr, e_ir, e_pc, e_br, e_jp, e_src, e_dst, e_m2r, e_rw, e_done, e_flt;
    logic [1:0]  e_alu;
    logic [17:0] exp_v, dut_v;
    mode = 0; i = 0; wt = 0; cls = C_R;
    forever begin
      @(negedge clock);
      {e_req, e_rd, e_wr, e_ir, e_pc, e_br, e_jp, e_src, e_dst, e_m2r, e_rw, e_done, e_flt} = '0;
      e_alu = 2'b00;
      e_state = K_IDLE;
      n_mode = mode; n_i = i; n_wt = wt; n_cls = cls;
      if (reset) begin
        n_mode = 0;
      end else if (mode == 0) begin
        if (bus.run) begin
          n_mode = 1; n_i = 0; n_wt = 0;
        end
      end else if (mode == 2) begin
        e_state = K_FAULT;
        e_flt   = 1'b1;
      end else begin
        kind      = kind_at(cls, i);
        e_state   = kind;
        memstep   = (kind == K_F) || (kind == K_M);
        completes = !memstep || bus.mem_ready;
        last      = (i == seq_len(cls) - 1);
        case (kind)
          K_F: begin
            e_req = 1'b1; e_rd = 1'b1;
            if (bus.mem_ready) begin e_ir = 1'b1; e_pc = 1'b1; end
          end
          K_D: n_cls = cls_of(bus.opcode);
          K_E: begin
            if (cls == C_JMP) begin e_jp = 1'b1; e_pc = 1'b1; e_alu = 2'b11; end
            else if (cls == C_BR) begin e_br = 1'b1; e_alu = 2'b01; end
            else if (cls == C_LW || cls == C_SW) begin e_alu = 2'b00; e_src = 1'b1; end
            else e_alu = 2'b10;
          end
          K_M: begin
            e_req = 1'b1; e_src = 1'b1;
            e_rd = (cls == C_LW); e_wr = (cls == C_SW);
          end
          default: begin
            e_rw = 1'b1;
            if (cls == C_LW) e_m2r = 1'b1; else e_dst = 1'b1;
          end
        endcase
        e_done = last && completes;
        if (!completes) begin
          if (wt == TMO) n_mode = 2;
          else n_wt = wt + 1;
        end else if (last) begin
          if (bus.run) begin n_i = 0; n_wt = 0; end
          else n_mode = 0;
        end else begin
          n_i = i + 1; n_wt = 0;
        end
      end
      exp_v = {e_req, e_rd, e_wr, e_ir, e_pc, e_br, e_jp, e_alu, e_src, e_dst, e_m2r,
               e_rw, e_done, e_flt, 3'(e_state)};
      dut_v = {bus.mem_req, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
               bus.branch, bus.jump, bus.alu_op, bus.alu_src, bus.reg_dst, bus.mem_to_reg,
               bus.reg_write, bus.instr_done, bus.fault, bus.state};
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t: got %h expected %h", $time, dut_v, exp_v);
      end
      if (bus.mem_req === 1'b1) begin
        checks++;
        if ((bus.mem_read ^ bus.mem_write) !== 1'b1) begin
          errors++;
          $display("FAIL one_hot_rw t=%0t: got read=%b write=%b expected exactly one",
                   $time, bus.mem_read, bus.mem_write);
        end
      end
      checks++;
      if ((bus.reg_write & bus.mem_write) !== 1'b0) begin
        errors++;
        $display("FAIL rw_exclusive t=%0t: got reg_write=%b mem_write=%b expected not both",
                 $time, bus.reg_write, bus.mem_write);
      end
      @(posedge clock);
      mode = n_mode; i = n_i; wt = n_wt; cls = n_cls;
    end
  end

  // Apply inputs just after the rising edge, then let outputs settle
  task automatic drive(input int r, input int rn, input int op, input int rdy);
    reset         = 1'(r);
    bus.run       = 1'(rn);
    bus.opcode    = 4'(op);
    bus.mem_ready = 1'(rdy);
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Directed stimulus with hand-computed literal expectations
  initial begin : stim
    drive(1, 1, 1, 1);
    chk3("reset_state", bus.state, 0);
    chk1("reset_mem_req", bus.mem_req, 0);
    chk1("reset_ir_write", bus.ir_write, 0);
    step();
    drive(1, 1, 1, 1);
    chk2("reset_alu_op", bus.alu_op, 0);
    step();

    // R-type, memory always ready: states 1,2,3,5 then 1
    drive(0, 1, 1, 1); chk3("rt_idle", bus.state, 0); step();
    drive(0, 1, 1, 1);
    chk3("rt_fetch", bus.state, 1);
    chk1("rt_ir_write", bus.ir_write, 1);
    chk1("rt_pc_write", bus.pc_write, 1);
    step();
    drive(0, 1, 1, 1); chk3("rt_decode", bus.state, 2); step();
    drive(0, 1, 1, 1); chk3("rt_exec", bus.state, 3); chk2("rt_alu_op", bus.alu_op, 2); step();
    drive(0, 1, 1, 1);
    chk3("rt_wb", bus.state, 5);
    chk1("rt_reg_write", bus.reg_write, 1);
    chk1("rt_reg_dst", bus.reg_dst, 1);
    chk1("rt_done", bus.instr_done, 1);
    step();

    // lw with three MEM wait cycles
    drive(0, 1, 2, 1); chk3("rt_back_to_fetch", bus.state, 1); step();
    drive(0, 1, 2, 1); step();
    drive(0, 1, 2, 1); chk1("lw_exec_alu_src", bus.alu_src, 1); step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 2, 0);
      chk1("lw_mem_req_held", bus.mem_req, 1);
      chk1("lw_mem_read_held", bus.mem_read, 1);
      step();
    end
    drive(0, 1, 2, 1); chk3("lw_mem_last", bus.state, 4); chk1("lw_mem_no_done", bus.instr_done, 0); step();
    drive(0, 1, 3, 1);
    chk3("lw_wb", bus.state, 5);
    chk1("lw_mem_to_reg", bus.mem_to_reg, 1);
    chk1("lw_reg_write", bus.reg_write, 1);
    chk1("lw_done", bus.instr_done, 1);
    step();

    // sw, memory ready
    drive(0, 1, 3, 1); chk3("sw_fetch", bus.state, 1); step();
    drive(0, 1, 3, 1); step();
    drive(0, 1, 3, 1); step();
    drive(0, 1, 3, 1);
    chk3("sw_mem", bus.state, 4);
    chk1("sw_mem_write", bus.mem_write, 1);
    chk1("sw_mem_read", bus.mem_read, 0);
    chk1("sw_done", bus.instr_done, 1);
    chk1("sw_no_reg_write", bus.reg_write, 0);
    step();

    // jump then branch, three cycles each
    drive(0, 1, 0, 1); chk3("jmp_fetch", bus.state, 1); step();
    drive(0, 1, 0, 1); step();
    drive(0, 1, 4, 1);
    chk1("jmp_jump", bus.jump, 1);
    chk1("jmp_pc_write", bus.pc_write, 1);
    chk2("jmp_alu_op", bus.alu_op, 3);
    chk1("jmp_done", bus.instr_done, 1);
    step();
    drive(0, 1, 4, 1); chk3("br_fetch", bus.state, 1); step();
    drive(0, 1, 4, 1); step();
    drive(0, 1, 15, 1);
    chk1("br_branch", bus.branch, 1);
    chk2("br_alu_op", bus.alu_op, 1);
    chk1("br_no_pc_write", bus.pc_write, 0);
    chk1("br_done", bus.instr_done, 1);
    step();

    // undefined opcode as R-type; run dropped in EXEC parks in IDLE after WB
    drive(0, 1, 15, 1); step();
    drive(0, 1, 15, 1); step();
    drive(0, 0, 15, 1); chk2("undef_alu_op", bus.alu_op, 2); step();
    drive(0, 0, 15, 1); chk3("rundrop_wb", bus.state, 5); chk1("rundrop_done", bus.instr_done, 1); step();
    drive(0, 0, 1, 1); chk3("rundrop_idle", bus.state, 0); step();
    drive(0, 0, 1, 1); chk3("rundrop_idle2", bus.state, 0); step();

    // FETCH wait: ready arriving in the expiry cycle proceeds normally
    drive(0, 1, 1, 0); step();
    for (int k = 0; k < TMO; k++) begin
      drive(0, 1, 1, 0); step();
    end
    drive(0, 1, 1, 1);
    chk3("tmo_edge_state", bus.state, 1);
    chk1("tmo_edge_ir_write", bus.ir_write, 1);
    chk1("tmo_edge_no_fault", bus.fault, 0);
    step();
    drive(0, 1, 1, 1); chk3("tmo_edge_decode", bus.state, 2); step();
    drive(0, 1, 1, 1); step();
    drive(0, 1, 1, 1); step();

    // FETCH never ready: FAULT after the full wait, exit only by reset
    for (int k = 0; k <= TMO; k++) begin
      drive(0, 1, 1, 0); step();
    end
    drive(0, 1, 1, 1);
    chk3("fault_state", bus.state, 7);
    chk1("fault_flag", bus.fault, 1);
    chk1("fault_no_req", bus.mem_req, 0);
    step();
    drive(0, 1, 1, 1); step();
    drive(1, 1, 3, 1); chk1("fault_reset_clears", bus.fault, 0); chk3("fault_reset_state", bus.state, 0); step();

    // sw aborted by reset during MEM
    drive(0, 1, 3, 1); step();
    drive(0, 1, 3, 1); step();
    drive(0, 1, 3, 1); step();
    drive(0, 1, 3, 1); step();
    drive(0, 1, 3, 0); chk3("abort_in_mem", bus.state, 4); step();
    drive(1, 0, 3, 0);
    chk1("abort_req_dropped", bus.mem_req, 0);
    chk1("abort_no_write", bus.mem_write, 0);
    step();
    drive(0, 0, 3, 0);
    chk3("abort_idle", bus.state, 0);
    chk1("abort_no_done", bus.instr_done, 0);
    step();

    // lw whose MEM access never completes
    drive(0, 1, 2, 1); step();
    drive(0, 1, 2, 1); step();
    drive(0, 1, 2, 1); step();
    drive(0, 1, 2, 1); step();
    for (int k = 0; k <= TMO; k++) begin
      drive(0, 1, 2, 0); step();
    end
    drive(0, 1, 2, 0);
    chk3("mem_tmo_state", bus.state, 7);
    chk1("mem_tmo_fault", bus.fault, 1);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
